// File: rtl/udp_tx_framer.sv
// udp_tx_framer: emits one Ethernet/IPv4/UDP frame per start request, payload passed through.
// Optional: define UDP_TX_IP_CSUM_EN to compute and insert the IPv4 header checksum.
module udp_tx_framer #(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'h01_00_5E_00_00_01,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP      = 32'hE000_0001,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd6000,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        err_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves on a cycle where valid && ready are both high at the
  // rising clock edge; the source holds data/last stable while valid && !ready.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CSUM    = 3'd1,
    ETH     = 3'd2,
    IP      = 3'd3,
    UDP     = 3'd4,
    PAYLOAD = 3'd5
  } state_t;

  state_t       state;
  logic [15:0]  cnt;
  logic [15:0]  len;
  logic [15:0]  ip_id;
  logic [15:0]  csum;
  logic [15:0]  tot_len;
  logic [15:0]  udp_len;
  logic [15:0]  last_idx;
  logic [335:0] hdr;
  logic [8:0]   bit_lo;
  logic         len_bad;

  assign tot_len  = len + 16'd28;
  assign udp_len  = len + 16'd8;
  assign last_idx = len + 16'd41;
  assign len_bad  = (payload_len == 16'd0) || (payload_len > 16'(MAX_PAYLOAD));

  // The 42 header bytes, byte 0 in the top octet.
  assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                8'h45, 8'h00, tot_len, ip_id, 16'h4000, IP_TTL, 8'h11, csum,
                SRC_IP, DST_IP,
                SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign bit_lo = {3'd0, 6'd41 - cnt[5:0]} << 3;

`ifdef UDP_TX_IP_CSUM_EN
  logic [19:0] csum_acc;
  logic [19:0] csum_f1;
  logic [19:0] csum_f2;

  // Ten words fit in 20 bits; two carry folds always bring the sum back to 16 bits.
  assign csum_acc = 20'h04500 + {4'd0, tot_len} + {4'd0, ip_id} + 20'h04000
                  + {4'd0, IP_TTL, 8'h11}
                  + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                  + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
  assign csum_f1  = {4'd0, csum_acc[15:0]} + {16'd0, csum_acc[19:16]};
  assign csum_f2  = {4'd0, csum_f1[15:0]} + {16'd0, csum_f1[19:16]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= 16'h0000;
    end else if (state == CSUM) begin
      csum <= ~csum_f2[15:0];
    end
  end
`else
  assign csum = 16'h0000;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      len     <= 16'd0;
      ip_id   <= 16'd0;
      err_len <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_bad) begin
              err_len <= 1'b1;
            end else begin
              len   <= payload_len;
              state <= CSUM;
            end
          end
        end
        CSUM: begin
          cnt   <= 16'd0;
          state <= ETH;
        end
        ETH, IP, UDP: begin
          if (tx_ready) begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd13) state <= IP;
            if (cnt == 16'd33) state <= UDP;
            if (cnt == 16'd41) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (pl_valid && tx_ready) begin
            cnt <= cnt + 16'd1;
            if (cnt == last_idx) begin
              ip_id <= ip_id + 16'd1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    pl_ready = 1'b0;
    case (state)
      ETH, IP, UDP: begin
        tx_valid = 1'b1;
        tx_data  = hdr[bit_lo +: 8];
      end
      PAYLOAD: begin
        tx_data  = pl_data;
        tx_valid = pl_valid;
        pl_ready = tx_ready;
        tx_last  = (cnt == last_idx);
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Testbench for udp_tx_framer: directed frames, expected bytes queued, monitor compares.
module tb_udp_tx_framer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] payload_len;
  logic        busy;
  logic        err_len;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [2:0]  state_dbg;

  logic [8:0]  exp_q[$];
  logic [7:0]  pl_q[$];
  logic [7:0]  pay[$];
  logic [7:0]  rx_q[$];
  int          byte_cnt;
  int          n_tests;
  int          n_fail;
  bit          pl_gate;
  logic        take;

  udp_tx_framer dut (
    .clk(clk), .reset(reset), .start(start), .payload_len(payload_len),
    .busy(busy), .err_len(err_len), .pl_data(pl_data), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] csum_model(input logic [15:0] tl, input logic [15:0] id);
    int unsigned s;
    s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'h4011
      + 32'hC0A8 + 32'h0001 + 32'hE000 + 32'h0001;
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  // Push the expected frame (header + pay[]) and hand pay[] to the payload source.
  task automatic push_frame(input logic [15:0] len, input logic [15:0] id);
    logic [7:0]  h[42];
    logic [15:0] tl;
    logic [15:0] ul;
    logic [15:0] ck;
    tl = len + 16'd28;
    ul = len + 16'd8;
`ifdef UDP_TX_IP_CSUM_EN
    ck = csum_model(tl, id);
`else
    ck = 16'h0000;
`endif
    h = '{8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00,
          8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0],
          8'h40, 8'h00, 8'h40, 8'h11, ck[15:8], ck[7:0],
          8'hC0, 8'hA8, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h00, 8'h01,
          8'h13, 8'h88, 8'h17, 8'h70, ul[15:8], ul[7:0], 8'h00, 8'h00};
    for (int i = 0; i < 42; i++) exp_q.push_back({1'b0, h[i]});
    for (int i = 0; i < pay.size(); i++) begin
      exp_q.push_back({(i == pay.size() - 1), pay[i]});
      pl_q.push_back(pay[i]);
    end
    byte_cnt = 0;
    rx_q.delete();
  endtask

  task automatic start_frame(input logic [15:0] len);
    @(posedge clk); #1;
    start       = 1'b1;
    payload_len = len;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int  k;
    bit  done;
    k    = 0;
    done = 1'b0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      k++;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (byte_cnt < n && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("wait_bytes", 32'(byte_cnt >= n), 32'd1);
  endtask

  task automatic check_csum;
    int unsigned s;
    s = 0;
    for (int i = 14; i < 34; i += 2) s += {16'd0, rx_q[i], rx_q[i + 1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`ifdef UDP_TX_IP_CSUM_EN
    check("ip_hdr_ones_sum", s, 32'h0000_FFFF);
`else
    check("csum_bytes_zero", {16'd0, rx_q[24], rx_q[25]}, 32'd0);
`endif
  endtask

  // Payload source: pops a byte after each accepted transfer
  initial begin
    pl_valid = 1'b0;
    pl_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = pl_valid && pl_ready;
      @(posedge clk); #1;
      if (take && pl_q.size() > 0) void'(pl_q.pop_front());
      pl_valid = pl_gate && (pl_q.size() > 0);
      pl_data  = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        byte_cnt++;
        rx_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {23'd0, tx_last, tx_data}, 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte_%0d", byte_cnt - 1), {23'd0, tx_last, tx_data}, {23'd0, e});
        end
      end
    end
  end

  // Stimulus
  initial begin
    n_tests     = 0;
    n_fail      = 0;
    byte_cnt    = 0;
    pl_gate     = 1'b1;
    reset       = 1'b1;
    start       = 1'b0;
    payload_len = 16'd0;
    tx_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    // Length errors
    start_frame(16'd0);
    check("len0_err", 32'(err_len), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("len0_err_pulse", 32'(err_len), 32'd0);
    check("len0_no_valid", 32'(tx_valid), 32'd0);
    start_frame(16'd1473);
    check("len1473_err", 32'(err_len), 32'd1);
    check("len1473_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("len1473_no_valid", 32'(tx_valid | busy), 32'd0);

    // Frame 1: basic, latency, ignored start
    pay = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    push_frame(16'd4, 16'h0000);
    start_frame(16'd4);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_valid", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_c2_first_byte", {23'd0, tx_valid, tx_data}, 32'h101);
    repeat (10) @(posedge clk);
    #1;
    start       = 1'b1;
    payload_len = 16'd4;
    @(posedge clk); #1;
    start       = 1'b0;
    wait_done("frame1_done");
    check("frame1_bytes", byte_cnt, 32'd46);
    check("frame1_tot_len", {16'd0, rx_q[16], rx_q[17]}, 32'h0020);
    check("frame1_udp_len", {16'd0, rx_q[38], rx_q[39]}, 32'h000C);
    check_csum();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Frame 2: tx_ready stall on byte 20, pl_valid gap mid-payload
    pay = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    push_frame(16'd4, 16'h0001);
    start_frame(16'd4);
    repeat (21) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("stall_byte20_a", {23'd0, tx_valid, tx_data}, 32'h140);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_byte20_b", {23'd0, tx_valid, tx_data}, 32'h140);
    end
    @(posedge clk); #1;
    check("stall_byte20_c", {23'd0, tx_valid, tx_data}, 32'h140);
    tx_ready = 1'b1;
    wait_bytes(44);
    pl_gate = 1'b0;
    #2;
    check("pl_gap_valid_a", 32'(tx_valid), 32'd0);
    @(posedge clk); #2;
    check("pl_gap_valid_b", 32'(tx_valid), 32'd0);
    pl_gate = 1'b1;
    wait_done("frame2_done");
    check("frame2_bytes", byte_cnt, 32'd46);
    check("frame2_id", {16'd0, rx_q[18], rx_q[19]}, 32'h0001);
    check_csum();

    // Frame 3: reset on payload byte 2
    pay = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    push_frame(16'd4, 16'h0002);
    start_frame(16'd4);
    wait_bytes(44);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pl_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame 4: complete after reset, identification back to zero
    pay = '{8'h55, 8'h66, 8'h77};
    push_frame(16'd3, 16'h0000);
    start_frame(16'd3);
    wait_done("frame4_done");
    check("frame4_bytes", byte_cnt, 32'd45);
    check("frame4_id", {16'd0, rx_q[18], rx_q[19]}, 32'h0000);
    check_csum();

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_framer.md
# udp_tx_framer

Transmit-side counterpart of the byte-serial Ethernet/IPv4/UDP receive parser. On a `start` request it emits one complete frame as a byte stream on a valid/ready interface. The frame is a 14-byte Ethernet header, a 20-byte IPv4 header, an 8-byte UDP header, then `payload_len` payload bytes passed through from an upstream byte source. It sits between the order/message generator and the MAC transmit path.

## Interface
- `SRC_MAC`, 48'h02_00_00_00_00_01: Ethernet source address.
- `DST_MAC`, 48'h01_00_5E_00_00_01: Ethernet destination address.
- `SRC_IP`, 32'hC0A8_0001: IPv4 source address.
- `DST_IP`, 32'hE000_0001: IPv4 destination address.
- `SRC_PORT`, 16'd5000: UDP source port.
- `DST_PORT`, 16'd6000: UDP destination port.
- `IP_TTL`, 8'd64: IPv4 TTL field.
- `MAX_PAYLOAD`, 1472: largest accepted `payload_len`.

Ports:
- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle frame request; sampled only in IDLE.
- `payload_len`  in  16  payload byte count; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `err_len`  out  1  one-cycle pulse when a frame request is rejected.
- `pl_data`  in  8  payload byte from upstream.
- `pl_valid`  in  1  `pl_data` is valid.
- `pl_ready`  out  1  the framer is taking `pl_data` this cycle.
- `tx_data`  out  8  frame byte to the MAC.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the MAC accepts the byte.
- `tx_last`  out  1  marks the final byte of the frame.

## Operation
- States: IDLE, CSUM, ETH, IP, UDP, PAYLOAD. A 16-bit byte counter `cnt` indexes the frame from 0.
- **IDLE:**
  - A request is `start`=1. It is rejected if `payload_len`==0 or `payload_len`>`MAX_PAYLOAD`.
  - Rejected request: pulse `err_len` and stay in IDLE.
  - Accepted request: latch `len` (the `payload_len` value) and go to CSUM.
- **CSUM:** lasts one cycle, with `tx_valid`=0. It registers the IPv4 checksum and clears `cnt`, then goes to ETH.
- **Header bytes** (ETH, IP and UDP states) are driven with `tx_valid`=1. `cnt` advances only on `tx_valid && tx_ready`.
  - ETH, `cnt` 0–13: `DST_MAC`, then `SRC_MAC`, then 0x08 0x00. All fields are sent MSB first. Go to IP after `cnt`==13 is transferred.
  - IP, `cnt` 14–33: 0x45, 0x00, total length = `len`+28, identification `ip_id`, 0x40 0x00, `IP_TTL`, 0x11, checksum, `SRC_IP`, `DST_IP`. Go to UDP after `cnt`==33.
  - UDP, `cnt` 34–41: `SRC_PORT`, `DST_PORT`, length = `len`+8, 0x00 0x00. Go to PAYLOAD after `cnt`==41.
- **PAYLOAD:** the framer passes bytes straight through.
  - `tx_data`=`pl_data`, `tx_valid`=`pl_valid`, `pl_ready`=`tx_ready`.
  - `tx_last`=1 when `cnt`==`len`+41.
  - After the last byte is transferred: increment `ip_id` and go to IDLE.
- **Checksum:**
  - Ones-complement sum of the ten header 16-bit words, with the checksum word taken as 0.
  - Use a 20-bit accumulator, fold the carry twice, then invert.
  - All length additions are 16-bit. No overflow is possible given `MAX_PAYLOAD`.
- `pl_ready`=0 in every state other than PAYLOAD.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: state IDLE, `cnt`=0, `ip_id`=0. All outputs are 0: `busy`, `err_len`, `pl_ready`, `tx_valid`, `tx_last`, `tx_data`.
- Reset is asynchronous. Asserting it mid-frame forces `tx_valid`=0 and IDLE immediately, and the partial frame is abandoned.
- Latency from `start`:
  - Cycle 0: `start` sampled.
  - Cycle 1: CSUM, with `busy`=1.
  - Cycle 2: first `tx_valid`=1 (byte 0x01 of `DST_MAC`).
- Back-to-back operation:
  - IDLE lasts at least one cycle after `tx_last` is transferred.
  - The minimum frame period is therefore 42+`len`+2 cycles with `tx_ready` held at 1.
- Backpressure: `tx_data`, `tx_valid` and `tx_last` are held stable while `tx_valid && !tx_ready`, in the header states.
- `err_len` asserts in the cycle after the rejected `start`.
- Outputs are combinational from state, `cnt` and the latched fields; the payload path is combinational pass-through.

## Configuration
- `UDP_TX_IP_CSUM_EN` defined: the CSUM state computes the header checksum, which is inserted at `cnt` 24–25.
- Not defined: the checksum bytes are 0x00 0x00. The checksum logic is removed, but the CSUM state is kept so latency is the same.

## Test plan
- **Basic frame:** `payload_len`=4, payload 0xA1..0xA4, `tx_ready`=1.
  - Exactly 46 bytes are sent, with `tx_last` only on byte 45.
  - Bytes 16–17 = 0x00 0x20, bytes 38–39 = 0x00 0x0C, bytes 42–45 = A1..A4.
- **Checksum** (macro defined): the bench sums the ten received IP header words in ones-complement and gets 0xFFFF.
  - With the macro undefined, bytes 24–25 are 0x0000.
- **Backpressure:**
  - Drop `tx_ready` for 3 cycles while on byte 20: byte 20 is held and no byte is skipped or duplicated.
  - Drop `pl_valid` mid-payload: `tx_valid`=0 and `cnt` holds.
- **Length errors:**
  - `payload_len`=0 → `err_len` pulse, `busy` stays 0, no `tx_valid`.
  - `payload_len`=1473 → same result.
- **Busy and ID:**
  - `start` during frame 1 is ignored.
  - Two frames carry identification 0x0000 and then 0x0001.
- **Reset:** assert `reset` on payload byte 2. `tx_valid`=0 with no clock edge, and the next frame is complete with identification 0x0000.
